floating_point_mixer: RTL and testbench
=======================================

// Module: floating_point_mixer
// PURPOSE
//  Sequential front end for floating_point_adder_subtracter. Sums NUM_CHANNELS
//  IEEE-754 single samples into one mixed sample, one operand per cycle, via a
//  single internal adder/subtracter instance.
//  Sits between per-voice sample sources (upstream) and the output sample path (downstream).
// PARAMETERS
//  NUM_CHANNELS  4  samples summed per frame; legal range 2..16
//  CW            $clog2(NUM_CHANNELS)  width of the channel counter (derived, do not override)
// PORTS
//  clk          in   1   single clock; all state on posedge
//  rst_n        in   1   reset, asynchronous assert, active-low
//  in_valid     in   1   in_sample/in_subtract valid
//  in_ready     out  1   mixer accepts an input this cycle
//  in_sample    in   32  IEEE-754 single operand
//  in_subtract  in   1   1: operand is subtracted from the running sum
//  in_ch        out  CW  index of the channel the next accepted sample belongs to
//  out_valid    out  1   mixed sample available
//  out_ready    in   1   downstream accepts out_sample
//  out_sample   out  32  mixed frame result, IEEE-754 single
// BEHAVIOUR
//  Reset: in_ready=0 during reset and 1 the first cycle after; out_valid=0,
//   out_sample=0, in_ch=0, accumulator=0; state=ACCUM.
//  Handshakes: input transfer = in_valid&in_ready on posedge; output transfer =
//   out_valid&out_ready. out_sample is stable while out_valid=1 and not accepted.
//  States:
//   ACCUM: in_ready=1, out_valid=0. On each input transfer:
//    - in_ch==0: acc <= {in_sample[31]^in_subtract, in_sample[30:0]}. Direct load,
//      no add; the adder does not handle zero/denormal operands.
//    - in_ch>0: acc <= adder(a=acc, b=in_sample, is_subtract=in_subtract).
//      Combinational adder, result registered the same edge.
//    - in_ch increments. On the transfer with in_ch==NUM_CHANNELS-1, in_ch wraps
//      to 0 and state -> OUTPUT.
//    - No transfer: acc and in_ch hold.
//   OUTPUT: in_ready=0, out_valid=1, out_sample=acc (post-gain, see CONFIGURATION).
//    On output transfer -> ACCUM. in_ready returns to 1 the next cycle
//    (one-cycle bubble; no same-cycle in/out overlap).
//  Latency: out_valid rises the cycle after the final input transfer of a frame.
//   Back-to-back frames: NUM_CHANNELS+1 cycles each when both sides are always ready.
//  in_valid while in OUTPUT: ignored (in_ready=0). Upstream holds data.
//  Reset mid-frame: partial sum discarded, in_ch->0; the next frame starts clean.
//  Arithmetic: adder limits apply (no inf/NaN/denormal handling). Overflow wraps per
//   adder; not flagged.
// CONFIGURATION
//  FP_MIXER_GAIN_EN defined: extra input port gain_shift [3:0], sampled at the final
//   input transfer. out_sample exponent = acc exponent - gain_shift, i.e. the result
//   is divided by 2^gain_shift.
//   If acc exponent <= gain_shift, out_sample = {sign, 31'b0} (flush to signed zero).
//   Sign and mantissa are untouched.
//  FP_MIXER_GAIN_EN undefined: no gain_shift port; out_sample = acc unmodified.
// TESTING
//  1. Reset, NUM_CHANNELS=4, all adds: 3F800000,40000000,3F000000,3F000000
//     -> out_sample=40800000 (4.0); out_valid rises 1 cycle after 4th transfer.
//  2. Mixed subtract: 40000000(+),3F000000(-),3F000000(-),3F000000(+)
//     -> 3FC00000 (1.5).
//  3. Subtract on channel 0: 3F800000(-),40000000(+),3F000000(+),3F000000(+)
//     -> 40000000 (2.0).
//  4. Backpressure: out_ready=0 for 5 cycles after frame; in_valid held 1
//     -> in_ready=0, out_sample stable; accept -> in_ready=1 next cycle, in_ch=0.
//  5. Assert rst_n=0 after 2 of 4 transfers; release; send test-1 frame
//     -> 40800000, no residue from the aborted frame.
//  6. FP_MIXER_GAIN_EN, gain_shift=1 with test-1 frame -> 40000000.
//     Same build, gain_shift=15, frame of 4x 00800000 -> 00000000 (flush to zero).

Source files
------------

// File: rtl/floating_point_mixer.sv
// floating_point_mixer: sums NUM_CHANNELS IEEE-754 single samples into one
// mixed sample per frame. Takes one operand per cycle and feeds it through a
// single combinational adder/subtracter.
// Optional feature macro: FP_MIXER_GAIN_EN adds a gain_shift port. The output
// is then divided by 2^gain_shift, flushing to signed zero on exponent underflow.

// Combinational single-precision add/sub for normal operands only.
// Rounding is truncation. There is no inf/NaN/denormal handling, and exponent
// overflow wraps.
module floating_point_adder_subtracter (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_subtract,
  output logic [31:0] result
);
  logic        big_s, sml_s;
  logic [7:0]  big_e, sml_e, d, res_e;
  logic [23:0] big_m, sml_m, sml_sh, norm;
  logic [24:0] sum;
  logic [4:0]  pos;
  logic [22:0] res_m;
  logic        zero;

  // Align the smaller magnitude to the larger one, add or subtract, then renormalise.
  always_comb begin
    if (b[30:0] > a[30:0]) begin
      big_s = b[31] ^ is_subtract; big_e = b[30:23]; big_m = {1'b1, b[22:0]};
      sml_s = a[31];               sml_e = a[30:23]; sml_m = {1'b1, a[22:0]};
    end else begin
      big_s = a[31];               big_e = a[30:23]; big_m = {1'b1, a[22:0]};
      sml_s = b[31] ^ is_subtract; sml_e = b[30:23]; sml_m = {1'b1, b[22:0]};
    end
    d      = big_e - sml_e;
    sml_sh = (d > 8'd23) ? 24'd0 : (sml_m >> d);
    pos    = 5'd0;
    norm   = 24'd0;
    zero   = 1'b0;
    if (big_s == sml_s) begin
      sum = {1'b0, big_m} + {1'b0, sml_sh};
      if (sum[24]) begin
        res_m = sum[23:1];
        res_e = big_e + 8'd1;
      end else begin
        res_m = sum[22:0];
        res_e = big_e;
      end
    end else begin
      sum = {1'b0, big_m - sml_sh};
      // Find the highest set bit; the last hit in the loop wins.
      for (int i = 0; i < 24; i++)
        if (sum[i]) pos = 5'(i);
      zero  = (sum == 25'd0);
      norm  = sum[23:0] << (5'd23 - pos);
      res_m = norm[22:0];
      res_e = big_e - {3'b0, 5'd23 - pos};
    end
    result = zero ? 32'd0 : {big_s, res_e, res_m};
  end
endmodule

module floating_point_mixer #(
  parameter  int NUM_CHANNELS = 4,
  localparam int CW           = $clog2(NUM_CHANNELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_sample,
  input  logic          in_subtract,
  output logic [CW-1:0] in_ch,
`ifdef FP_MIXER_GAIN_EN
  input  logic [3:0]    gain_shift,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sample
);
  typedef enum logic {ACCUM, OUTPUT} state_t;

  localparam logic [CW-1:0] LAST = CW'(NUM_CHANNELS - 1);

  state_t      state;
  logic [31:0] acc, add_res, acc_nxt, out_nxt;
  logic        in_xfer;

  floating_point_adder_subtracter u_add (
    .a           (acc),
    .b           (in_sample),
    .is_subtract (in_subtract),
    .result      (add_res)
  );

  assign in_xfer = in_valid & in_ready;

  // Channel 0 loads directly, because the adder cannot take a zero accumulator.
  always_comb begin
    acc_nxt = (in_ch == '0) ? {in_sample[31] ^ in_subtract, in_sample[30:0]} : add_res;
`ifdef FP_MIXER_GAIN_EN
    if ({4'd0, acc_nxt[30:23]} <= {8'd0, gain_shift})
      out_nxt = {acc_nxt[31], 31'd0};
    else
      out_nxt = {acc_nxt[31], acc_nxt[30:23] - {4'd0, gain_shift}, acc_nxt[22:0]};
`else
    out_nxt = acc_nxt;
`endif
  end

  // Frame FSM with registered handshake outputs.
  // out_sample is captured, with gain applied, on the final input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= 32'd0;
      in_ch      <= '0;
      acc        <= 32'd0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            acc <= acc_nxt;
            if (in_ch == LAST) begin
              in_ch      <= '0;
              state      <= OUTPUT;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
              out_sample <= out_nxt;
            end else begin
              in_ch <= in_ch + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_point_mixer.sv
// Directed bench for floating_point_mixer with NUM_CHANNELS=4.
// Gain checks are built only when FP_MIXER_GAIN_EN is defined.
module tb_floating_point_mixer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sample;
  logic        in_subtract;
  logic [1:0]  in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sample;
`ifdef FP_MIXER_GAIN_EN
  logic [3:0]  gain_shift;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] held;

  always #5 clk = ~clk;

  floating_point_mixer #(.NUM_CHANNELS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .in_subtract (in_subtract),
    .in_ch       (in_ch),
`ifdef FP_MIXER_GAIN_EN
    .gain_shift  (gain_shift),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sample  (out_sample)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one sample, wait a bounded time for in_ready, then transfer it on the next edge.
  task automatic send(input logic [31:0] s, input logic sub, input int ch);
    int n = 0;
    in_valid = 1'b1; in_sample = s; in_subtract = sub;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    check("in_ch", 32'(in_ch), 32'(ch));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] s0, s1, s2, s3, input logic [3:0] sub);
    send(s0, sub[0], 0);
    send(s1, sub[1], 1);
    send(s2, sub[2], 2);
    send(s3, sub[3], 3);
    check("out_valid_rise", 32'(out_valid), 32'd1);
    check("in_ready_out", 32'(in_ready), 32'd0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("in_ch_back", 32'(in_ch), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sample = 32'd0; in_subtract = 1'b0; out_ready = 1'b0;
`ifdef FP_MIXER_GAIN_EN
    gain_shift = 4'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sample", out_sample, 32'd0);
    check("rst_in_ch", 32'(in_ch), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1.0 + 2.0 + 0.5 + 0.5 = 4.0
    frame(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0000);
    check("t1_sum", out_sample, 32'h40800000);
    accept();

    // 2.0 - 0.5 - 0.5 + 0.5 = 1.5
    frame(32'h40000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 4'b0110);
    check("t2_mixed", out_sample, 32'h3FC00000);
    accept();

    // -1.0 + 2.0 + 0.5 + 0.5 = 2.0, then hold the output under backpressure
    frame(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0001);
    check("t3_sub_ch0", out_sample, 32'h40000000);
    held = out_sample;
    in_valid = 1'b1; in_sample = 32'h41200000; in_subtract = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_in_ready_blocked", 32'(in_ready), 32'd0);
      check("t4_out_stable", out_sample, held);
      check("t4_out_valid_held", 32'(out_valid), 32'd1);
    end
    check("t4_in_ch_hold", 32'(in_ch), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("t4_in_ready_next", 32'(in_ready), 32'd1);
    check("t4_in_ch_zero", 32'(in_ch), 32'd0);

    // Abort a frame after two transfers
    send(32'h40000000, 1'b0, 0);
    send(32'h40000000, 1'b0, 1);
    @(negedge clk); rst_n = 1'b0;
    #2;
    check("t5_rst_in_ch", 32'(in_ch), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    frame(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0000);
    check("t5_clean_sum", out_sample, 32'h40800000);
    accept();

`ifdef FP_MIXER_GAIN_EN
    gain_shift = 4'd1;
    frame(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0000);
    check("t6_gain1", out_sample, 32'h40000000);
    accept();
    gain_shift = 4'd15;
    frame(32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000, 4'b0000);
    check("t6_flush", out_sample, 32'h00000000);
    accept();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
